des_iter_core: RTL and testbench

- Iterative, parametrised DES engine that computes ROUNDS_PER_CYCLE Feistel rounds per clock and supports both encrypt and decrypt.
- Accepts one 64-bit block plus 64-bit key per valid/ready handshake and returns the result over a second valid/ready handshake.
- Succeeds our earlier purely combinational DES datapath; it is the registered crypto engine instantiated behind the bus-facing crypto wrapper.

---
 rtl/des_pkg.sv | 154 +++++++++++++++
 rtl/des_iter_core_round.sv | 31 +++
 rtl/des_iter_core.sv | 148 ++++++++++++++
 tb/tb_des_iter_core.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants and pure functions: permutation tables, S-boxes, key schedule
// shifts, plus the round function used by the iterative core.
package des_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} des_state_e;
    typedef enum logic [2:0] {PT_IP, PT_FP, PT_E, PT_P, PT_PC1, PT_PC2} perm_e;

    // Bit n set means n is an accepted unroll factor (1, 2, 4, 8, 16).
    localparam logic [16:0] RPC_LEGAL = 17'h10116;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{
        32,1,2,3,4,5,     4,5,6,7,8,9,       8,9,10,11,12,13,   12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
        10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5,   3,28,15,6,21,10,   23,19,12,4,26,8,   16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    // Index 0 is unused so the schedule can be addressed by round number directly.
    localparam int SHIFT [17] = '{0, 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic bit rpc_legal(input int n);
        return (n >= 1 && n <= 16) ? RPC_LEGAL[n[4:0]] : 1'b0;
    endfunction

    function automatic int perm_in_w(input perm_e sel);
        case (sel)
            PT_E, PT_P: return 32;
            PT_PC2:     return 56;
            default:    return 64;
        endcase
    endfunction

    function automatic int perm_out_w(input perm_e sel);
        case (sel)
            PT_E, PT_PC2: return 48;
            PT_P:         return 32;
            PT_PC1:       return 56;
            default:      return 64;
        endcase
    endfunction

    function automatic int perm_tab(input perm_e sel, input int i);
        case (sel)
            PT_IP:   return IP_T[i[5:0]];
            PT_FP:   return FP_T[i[5:0]];
            PT_E:    return E_T[i[5:0]];
            PT_P:    return P_T[i[4:0]];
            PT_PC1:  return PC1_T[i[5:0]];
            default: return PC2_T[i[5:0]];
        endcase
    endfunction

    // Values are right-aligned; DES bit n of a w-bit field lives at x[w-n].
    function automatic logic [63:0] des_permute(input perm_e sel, input logic [63:0] x);
        logic [63:0] y;
        int in_w, out_w;
        y = '0;
        in_w = perm_in_w(sel);
        out_w = perm_out_w(sel);
        for (int i = 0; i < 64; i++) begin
            if (i < out_w) y[out_w - 1 - i] = x[in_w - perm_tab(sel, i)];
        end
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] key);
        logic [63:0] t;
        t = des_permute(PT_PC1, key);
        return t[55:0];
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] cd);
        logic [63:0] t;
        t = des_permute(PT_PC2, {8'b0, cd});
        return t[47:0];
    endfunction

    function automatic logic [3:0] des_sbox(input logic [2:0] n, input logic [5:0] b);
        return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] e;
        logic [47:0] x;
        logic [31:0] s;
        logic [63:0] p;
        e = des_permute(PT_E, {32'b0, r});
        x = e[47:0] ^ k;
        for (int i = 0; i < 8; i++) begin
            s[31 - 4*i -: 4] = des_sbox(3'(i), x[47 - 6*i -: 6]);
        end
        p = des_permute(PT_P, {32'b0, s});
        return p[31:0];
    endfunction

    function automatic logic [1:0] shift_of(input logic [4:0] rnd);
        return 2'(SHIFT[rnd]);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Odd parity expected in every key byte.
    function automatic logic des_key_par_err(input logic [63:0] key);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (~^key[8*i +: 8]) err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/des_iter_core_round.sv
// One combinational DES Feistel round with its key-schedule step.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [55:0] cd_i,
    input  logic [4:0]  rnd_i,
    input  logic        dec_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o,
    output logic [55:0] cd_o
);

    logic [4:0]  dec_idx;
    logic [55:0] cd_rot;
    logic [55:0] cd_back;
    logic [47:0] k;

    // Decrypt walks the schedule backwards: use the current CD, then undo shift 17-r.
    always_comb begin
        dec_idx = 5'd17 - rnd_i;
        cd_rot  = {rotl28(cd_i[55:28], shift_of(rnd_i)), rotl28(cd_i[27:0], shift_of(rnd_i))};
        cd_back = {rotr28(cd_i[55:28], shift_of(dec_idx)), rotr28(cd_i[27:0], shift_of(dec_idx))};
        k       = des_pc2(dec_i ? cd_i : cd_rot);
        l_o     = r_i;
        r_o     = l_i ^ des_f(r_i, k);
        cd_o    = dec_i ? cd_back : cd_rot;
    end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE chained rounds per clock behind
// valid/ready request and result handshakes.
//   state  | meaning
//   IDLE   | in_ready high, waiting for a block
//   RUN    | applying rounds, rcnt = rounds completed so far
//   DONE   | result held on out_data until out_ready
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CHECK_PARITY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_key,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        key_par_err
);

    if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // A step of 16 wraps the 4-bit counter to 0, which is also the last-round value.
    localparam logic [3:0] RPC_STEP  = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0] LAST_RCNT = 4'(16 - ROUNDS_PER_CYCLE);

    des_state_e  state_q, state_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [55:0] cd_q, cd_d;
    logic        mode_q, mode_d;
    logic        par_q, par_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        kerr_q, kerr_d;

    logic [31:0] l_c  [ROUNDS_PER_CYCLE+1];
    logic [31:0] r_c  [ROUNDS_PER_CYCLE+1];
    logic [55:0] cd_c [ROUNDS_PER_CYCLE+1];
    logic [63:0] ip_w;
    logic [55:0] pc1_w;
    logic [63:0] fp_w;

    assign l_c[0]  = l_q;
    assign r_c[0]  = r_q;
    assign cd_c[0] = cd_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        des_round u_round (
            .l_i   (l_c[g]),
            .r_i   (r_c[g]),
            .cd_i  (cd_c[g]),
            .rnd_i ({1'b0, rcnt_q} + 5'(g + 1)),
            .dec_i (mode_q),
            .l_o   (l_c[g+1]),
            .r_o   (r_c[g+1]),
            .cd_o  (cd_c[g+1])
        );
    end

    assign ip_w  = des_permute(PT_IP, in_data);
    assign pc1_w = des_pc1(in_key);
    assign fp_w  = des_permute(PT_FP, {r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        l_d         = l_q;
        r_d         = r_q;
        cd_d        = cd_q;
        mode_d      = mode_q;
        par_d       = par_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        kerr_d      = kerr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    l_d     = ip_w[63:32];
                    r_d     = ip_w[31:0];
                    cd_d    = pc1_w;
                    mode_d  = in_decrypt;
                    par_d   = des_key_par_err(in_key);
                    rcnt_d  = 4'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                l_d    = l_c[ROUNDS_PER_CYCLE];
                r_d    = r_c[ROUNDS_PER_CYCLE];
                cd_d   = cd_c[ROUNDS_PER_CYCLE];
                rcnt_d = rcnt_q + RPC_STEP;
                if (rcnt_q == LAST_RCNT) begin
                    out_data_d  = fp_w;
                    kerr_d      = par_q & (CHECK_PARITY != 0);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rcnt_q      <= 4'd0;
            l_q         <= '0;
            r_q         <= '0;
            cd_q        <= '0;
            mode_q      <= 1'b0;
            par_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            kerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            cd_q        <= cd_d;
            mode_q      <= mode_d;
            par_q       <= par_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            kerr_q      <= kerr_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign key_par_err = kerr_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench: three core configurations share one stimulus stream and are
// checked against known DES vectors, latencies, backpressure and mid-run reset.
module tb_des_iter_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_decrypt = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_key = '0;
    logic [63:0] in_data = '0;
    logic [2:0]  in_ready, out_valid, key_par_err;
    logic [63:0] out_data [3];

    int total = 0;
    int bad = 0;

    // Instance 0: RPC=1 parity on; 1: RPC=4 parity off; 2: RPC=16 parity on.
    localparam int LAT [3] = '{16, 4, 1};
    localparam int CPF [3] = '{1, 0, 1};

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1P = 64'h123457799BBCDFF1;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2  = 64'h8787878787878787;

    always #5 clk = ~clk;

    des_iter_core #(.ROUNDS_PER_CYCLE(1), .CHECK_PARITY(1)) u_rpc1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_decrypt(in_decrypt), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .key_par_err(key_par_err[0]));

    des_iter_core #(.ROUNDS_PER_CYCLE(4), .CHECK_PARITY(0)) u_rpc4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_decrypt(in_decrypt), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .key_par_err(key_par_err[1]));

    des_iter_core #(.ROUNDS_PER_CYCLE(16), .CHECK_PARITY(1)) u_rpc16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_decrypt(in_decrypt), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .key_par_err(key_par_err[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one block to all instances, measure latency, check result, optionally
    // stall the result for 'hold' cycles, then release it.
    task automatic run_block(input string tag, input logic dec, input logic [63:0] key,
                             input logic [63:0] data, input logic [63:0] expd,
                             input logic perr, input int hold);
        int lat [3];
        lat = '{0, 0, 0};
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = dec; in_key = key; in_data = data;
        @(posedge clk); #1;
        in_valid = 1'b0; in_decrypt = ~dec; in_key = '1; in_data = ~data;
        for (int e = 1; e <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); e++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (out_valid[d] && lat[d] == 0) lat[d] = e;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_lat%0d", tag, d), 64'(lat[d]), 64'(LAT[d]));
            chk($sformatf("%s_data%0d", tag, d), out_data[d], expd);
            chk($sformatf("%s_kerr%0d", tag, d), 64'(key_par_err[d]), 64'(perr & (CPF[d] != 0)));
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            in_valid = c[0]; in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom};
            @(posedge clk); #1;
            chk($sformatf("%s_hold_v%0d", tag, c), 64'(out_valid[0]), 64'd1);
            chk($sformatf("%s_hold_d%0d", tag, c), out_data[0], expd);
            chk($sformatf("%s_hold_rdy%0d", tag, c), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_rel_v"}, 64'(out_valid), 64'd0);
        chk({tag, "_rel_rdy"}, 64'(in_ready), 64'h7);
    endtask

    initial begin
        int quiet;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'h7);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data[0], 64'd0);
        chk("rst_kerr", 64'(key_par_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_block("enc1", 1'b0, K1, P1, C1, 1'b0, 0);
        run_block("dec1", 1'b1, K1, C1, P1, 1'b0, 0);
        run_block("enc2", 1'b0, K2, P2, 64'd0, 1'b0, 0);
        run_block("par", 1'b0, K1P, P1, C1, 1'b1, 0);
        run_block("bp", 1'b0, K1, P1, C1, 1'b0, 10);
        run_block("b2b", 1'b0, K2, P2, 64'd0, 1'b0, 0);

        // Abort a block after rcnt reaches 7 on the single-round instance.
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = 1'b0; in_key = K2; in_data = P2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'h7);
        chk("abort_data", out_data[0], 64'd0);
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid != 3'b000) quiet++;
        end
        chk("abort_quiet", 64'(quiet), 64'd0);
        run_block("post_rst", 1'b0, K1, P1, C1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
